// File: rtl/async_fifo_pkg.sv
// ---------------------------------------------------------------------------
// async_fifo_pkg
// Shared types for the read-side FIFO merge block (async_fifo_rr_mux) and
// its round-robin arbiter.
//   lock_state_t : packet-lock FSM state (UNLOCKED / LOCKED)
// The payload stays a raw vector, so no struct typedef lives here.
// ---------------------------------------------------------------------------
package async_fifo_pkg;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

endpackage : async_fifo_pkg

// File: rtl/async_fifo_rr_mux_arbiter.sv
// ---------------------------------------------------------------------------
// round_robin_arbiter
// Purely combinational round-robin arbiter.
// The search starts at the port after ptr and wraps modulo NUM_PORTS.
//   req         in  NUM_PORTS  request vector (one bit per port)
//   ptr         in  SRC_WIDTH  last granted port
//   grant       out SRC_WIDTH  index of the winning port (0 when no request)
//   grant_valid out 1          at least one request is present
// ---------------------------------------------------------------------------
module round_robin_arbiter
    import async_fifo_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int SRC_WIDTH = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [SRC_WIDTH-1:0] ptr,
    output logic [SRC_WIDTH-1:0] grant,
    output logic                 grant_valid
);

    localparam int DBL = 2 * NUM_PORTS;

    logic [DBL-1:0] req_dbl;
    logic [DBL-1:0] mask;
    logic [DBL-1:0] masked;
    logic           found;

    // The request vector is duplicated and every position up to and
    // including ptr is masked off. The first set bit of the masked vector
    // is then the next requester after ptr, wrapping through the upper copy.
    assign req_dbl = {req, req};

    always_comb begin
        mask = '0;
        for (int j = 0; j < DBL; j++) begin
            mask[j] = (j > int'(ptr));
        end
    end

    assign masked = req_dbl & mask;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int j = 0; j < DBL; j++) begin
            if (!found && masked[j]) begin
                found = 1'b1;
                grant = SRC_WIDTH'(j % NUM_PORTS);
            end
        end
    end

    // The upper copy holds every port, so any request yields a winner.
    assign grant_valid = |req;

endmodule : round_robin_arbiter

// File: rtl/async_fifo_rr_mux.sv
// ---------------------------------------------------------------------------
// async_fifo_rr_mux
// Read-side merge of NUM_PORTS async FIFO read ports (all in r_clk) into one
// registered valid/ready stream. Round-robin arbitration, optional packet
// lock that holds the grant until a beat with in_last=1 transfers.
//   r_clk     in  1                      read-domain clock
//   r_rstn    in  1                      async active-low reset
//   in_valid  in  NUM_PORTS              per-port FIFO r_valid
//   in_ready  out NUM_PORTS              per-port FIFO r_ready (one-hot or 0)
//   in_data   in  DATA_WIDTH x NUM_PORTS per-port payload
//   in_last   in  NUM_PORTS              per-port end-of-packet
//   out_valid out 1                      output beat valid
//   out_ready in  1                      consumer ready
//   out_data  out DATA_WIDTH             registered payload
//   out_last  out 1                      registered end-of-packet
//   out_src   out SRC_WIDTH              source port of the current beat
// ---------------------------------------------------------------------------
module async_fifo_rr_mux
    import async_fifo_pkg::*;
#(
    parameter int NUM_PORTS    = 4,
    parameter int DATA_WIDTH   = 32,
    parameter bit LOCK_ON_LAST = 1'b1,
    parameter int SRC_WIDTH    = $clog2(NUM_PORTS)
) (
    input  logic                  r_clk,
    input  logic                  r_rstn,
    input  logic [NUM_PORTS-1:0]  in_valid,
    output logic [NUM_PORTS-1:0]  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data [NUM_PORTS],
    input  logic [NUM_PORTS-1:0]  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic [SRC_WIDTH-1:0]  out_src
);

    lock_state_t          state;
    lock_state_t          state_next;
    logic [SRC_WIDTH-1:0] lock_port;
    logic [SRC_WIDTH-1:0] lock_port_next;
    logic [SRC_WIDTH-1:0] rr_ptr;

    logic [SRC_WIDTH-1:0] arb_grant;
    logic                 arb_valid;
    logic [SRC_WIDTH-1:0] grant;
    logic                 grant_valid;
    logic                 load;
    logic                 xfer;

    round_robin_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .SRC_WIDTH (SRC_WIDTH)
    ) u_arb (
        .req         (in_valid),
        .ptr         (rr_ptr),
        .grant       (arb_grant),
        .grant_valid (arb_valid)
    );

    // While a packet is in flight only its port may be granted; if that port
    // has nothing this cycle a bubble is inserted rather than interleaving.
    always_comb begin
        grant       = arb_grant;
        grant_valid = arb_valid;
        if (state == LOCKED) begin
            grant       = lock_port;
            grant_valid = in_valid[lock_port];
        end
    end

    // Single output register: it can be refilled in the same cycle it is
    // drained, giving one beat per cycle under continuous out_ready.
    assign load = !out_valid || out_ready;
    assign xfer = load && grant_valid;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            in_ready[i] = xfer && (grant == SRC_WIDTH'(i));
        end
    end

    // Lock FSM: state register
    always_ff @(posedge r_clk or negedge r_rstn) begin
        if (!r_rstn) begin
            state     <= UNLOCKED;
            lock_port <= '0;
        end else begin
            state     <= state_next;
            lock_port <= lock_port_next;
        end
    end

    // Lock FSM: next state. Without LOCK_ON_LAST it never leaves UNLOCKED.
    always_comb begin
        state_next     = state;
        lock_port_next = lock_port;
        if (LOCK_ON_LAST && xfer) begin
            lock_port_next = grant;
            state_next     = in_last[grant] ? UNLOCKED : LOCKED;
        end
    end

    // Output register and round-robin pointer. The pointer resets to the
    // last port so that port 0 has first priority.
    always_ff @(posedge r_clk or negedge r_rstn) begin
        if (!r_rstn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= '0;
            rr_ptr    <= SRC_WIDTH'(NUM_PORTS - 1);
        end else if (load) begin
            if (grant_valid) begin
                out_valid <= 1'b1;
                out_data  <= in_data[grant];
                out_last  <= in_last[grant];
                out_src   <= grant;
                rr_ptr    <= grant;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule : async_fifo_rr_mux
